// File: rtl/fix_bodylength_acc_pkg.sv
// fix_len_pkg: shared FSM states, ASCII constants and BCD sizing helpers for the BodyLength generator
package fix_len_pkg;
  typedef enum logic [2:0] {IDLE, ACCUM, CONV, NORM, HOLD} state_t;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  function automatic int bcd_width(input int max_digits);
    return 4 * max_digits;
  endfunction
  function automatic int conv_digits(input int len_width);
    return (len_width * 302 + 999) / 1000 + 1;
  endfunction
endpackage

// File: rtl/fix_bodylength_acc_if.sv
// fix_bodylength_acc_if: field-stream / result handshake bundle between sequencer and BodyLength generator
interface fix_bodylength_acc_if #(
  parameter int LEN_WIDTH = 16,
  parameter int FIELD_LEN_WIDTH = 8,
  parameter int MAX_DIGITS = 5
);
  logic start_i;
  logic field_valid_i;
  logic [FIELD_LEN_WIDTH-1:0] field_len_i;
  logic end_i;
  logic ack_i;
  logic busy_o;
  logic valid_o;
  logic [LEN_WIDTH-1:0] len_bin_o;
  logic [8*MAX_DIGITS-1:0] ascii_o;
  logic [$clog2(MAX_DIGITS+1)-1:0] digits_o;
  logic overflow_o;
  modport master (
    output start_i, field_valid_i, field_len_i, end_i, ack_i,
    input busy_o, valid_o, len_bin_o, ascii_o, digits_o, overflow_o
  );
  modport slave (
    input start_i, field_valid_i, field_len_i, end_i, ack_i,
    output busy_o, valid_o, len_bin_o, ascii_o, digits_o, overflow_o
  );
endinterface

// File: rtl/fix_bodylength_acc_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle, done pulses the cycle after the last shift
module bin2bcd_seq #(
  parameter int BIN_W = 16,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(BIN_W + 1);
  logic [BIN_W-1:0] sh;
  logic [CW-1:0] cnt;
  logic [4*DIGITS-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++)
      adj[4*d+:4] = bcd[4*d+:4] > 4'd4 ? bcd[4*d+:4] + 4'd3 : bcd[4*d+:4];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh <= '0;
      cnt <= '0;
      bcd <= '0;
      done <= 1'b0;
    end else begin
      done <= cnt == CW'(1);
      if (start) begin
        sh <= bin;
        bcd <= '0;
        cnt <= CW'(BIN_W);
      end else if (cnt != '0) begin
        {bcd, sh} <= {adj, sh} << 1;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/fix_bodylength_acc.sv
// fix_bodylength_acc: sums streamed field lengths plus overhead and emits FIX BodyLength as left-justified ASCII
module fix_bodylength_acc
  import fix_len_pkg::*;
#(
  parameter int LEN_WIDTH = 16,
  parameter int FIELD_LEN_WIDTH = 8,
  parameter int MAX_DIGITS = 5,
  parameter int FIXED_OVERHEAD = 0
) (
  input logic clk,
  input logic rst,
  fix_bodylength_acc_if.slave bus
);
  localparam int CD = conv_digits(LEN_WIDTH);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam int SW = LEN_WIDTH + 2;
  localparam logic [LEN_WIDTH-1:0] MAXV = '1;
  state_t state, state_nxt;
  logic [LEN_WIDTH-1:0] acc, total, len_bin;
  logic [SW-1:0] s;
  logic sat, ovf, ovf_out, conv_start, conv_done, big;
  logic [bcd_width(CD)-1:0] bcd;
  logic [8*MAX_DIGITS-1:0] ascii, ascii_nxt;
  logic [DW-1:0] digits, digits_nxt;
  int n;
  bin2bcd_seq #(.BIN_W(LEN_WIDTH), .DIGITS(CD)) u_conv (
    .clk(clk), .rst(rst), .start(conv_start), .bin(total), .done(conv_done), .bcd(bcd)
  );
  // a start in ACCUM discards the running sum, so its coincident field opens the new message
  always_comb begin
    s = SW'(state == ACCUM && !bus.start_i ? acc : '0)
      + (bus.field_valid_i ? SW'(bus.field_len_i) : '0)
      + (bus.end_i && !bus.start_i ? SW'(FIXED_OVERHEAD) : '0);
    sat = s > SW'(MAXV);
    total = sat ? MAXV : s[LEN_WIDTH-1:0];
    conv_start = state == ACCUM && bus.end_i && !bus.start_i;
  end
  always_ff @(posedge clk) state <= !rst ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (bus.start_i ? ACCUM : IDLE) :
                state == ACCUM ? (conv_start ? CONV : ACCUM) :
                state == CONV  ? (conv_done ? NORM : CONV) :
                state == NORM  ? HOLD :
                                 (bus.ack_i ? IDLE : HOLD);
  always_comb begin
    bus.busy_o = state != IDLE;
    bus.valid_o = state == HOLD;
  end
  // leading-zero strip: n is the count of significant BCD digits, never below one
  always_comb begin
    n = 1;
    for (int i = 1; i < CD; i++)
      if (bcd[4*i+:4] != 4'd0) n = i + 1;
    big = n > MAX_DIGITS;
    ascii_nxt = '0;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (big) ascii_nxt[8*i+:8] = ASCII_NINE;
      else if (i < n) ascii_nxt[8*i+:8] = ASCII_ZERO | {4'h0, bcd[4*(n-1-i)+:4]};
    digits_nxt = big ? DW'(MAX_DIGITS) : DW'(n);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      ovf <= 1'b0;
      len_bin <= '0;
      ascii <= '0;
      digits <= '0;
      ovf_out <= 1'b0;
    end else begin
      if (state == IDLE && bus.start_i) begin
        acc <= '0;
        ovf <= 1'b0;
      end
      if (state == ACCUM) begin
        acc <= total;
        ovf <= (ovf && !bus.start_i) || sat;
        if (conv_start) len_bin <= total;
      end
      if (state == NORM) begin
        ascii <= ascii_nxt;
        digits <= digits_nxt;
        ovf_out <= ovf || big;
      end
    end
  end
  assign bus.len_bin_o = len_bin;
  assign bus.ascii_o = ascii;
  assign bus.digits_o = digits;
  assign bus.overflow_o = ovf_out;
endmodule

// File: tb/tb_fix_bodylength_acc.sv
// tb_fix_bodylength_acc: three configurations driven by one shared stimulus stream, checked against hand-computed results
module tb_fix_bodylength_acc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, fv = 1'b0, en = 1'b0, ack = 1'b0;
  logic [7:0] fl = '0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int k;
  always #5 clk = ~clk;
  fix_bodylength_acc_if #(.MAX_DIGITS(5)) i0 ();
  fix_bodylength_acc_if #(.MAX_DIGITS(5)) i1 ();
  fix_bodylength_acc_if #(.MAX_DIGITS(3)) i2 ();
  assign i0.start_i = start;
  assign i0.field_valid_i = fv;
  assign i0.field_len_i = fl;
  assign i0.end_i = en;
  assign i0.ack_i = ack;
  assign i1.start_i = start;
  assign i1.field_valid_i = fv;
  assign i1.field_len_i = fl;
  assign i1.end_i = en;
  assign i1.ack_i = ack;
  assign i2.start_i = start;
  assign i2.field_valid_i = fv;
  assign i2.field_len_i = fl;
  assign i2.end_i = en;
  assign i2.ack_i = ack;
  fix_bodylength_acc #(.MAX_DIGITS(5), .FIXED_OVERHEAD(0))  d0 (.clk(clk), .rst(rst), .bus(i0));
  fix_bodylength_acc #(.MAX_DIGITS(5), .FIXED_OVERHEAD(13)) d1 (.clk(clk), .rst(rst), .bus(i1));
  fix_bodylength_acc #(.MAX_DIGITS(3), .FIXED_OVERHEAD(0))  d2 (.clk(clk), .rst(rst), .bus(i2));

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic start_msg;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic field(input int len);
    fv = 1'b1;
    fl = 8'(len);
    tick();
    fv = 1'b0;
  endtask
  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i0.valid_o) begin
        cycles = i;
        break;
      end
    end
    @(negedge clk);
  endtask
  task automatic end_msg(output int cycles);
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_valid(cycles);
  endtask
  task automatic do_ack;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    total_cnt++; if ({i0.busy_o, i0.valid_o, i0.overflow_o} !== 3'b000) $display("FAIL reset_flags got %b want 000", {i0.busy_o, i0.valid_o, i0.overflow_o}); else pass_cnt++;
    total_cnt++; if (i0.len_bin_o !== 16'd0 || i0.ascii_o !== 40'h0 || i0.digits_o !== 3'd0) $display("FAIL reset_data got %h %h %0d want 0", i0.len_bin_o, i0.ascii_o, i0.digits_o); else pass_cnt++;
  endtask

  task automatic test_basic;
    start_msg();
    field(5);
    field(7);
    field(10);
    end_msg(k);
    total_cnt++; if (k !== 18) $display("FAIL basic_latency got %0d want 18", k); else pass_cnt++;
    total_cnt++; if (i0.len_bin_o !== 16'd22) $display("FAIL basic_len got %0d want 22", i0.len_bin_o); else pass_cnt++;
    total_cnt++; if (i0.ascii_o !== 40'h0000003232) $display("FAIL basic_ascii got %h want 0000003232", i0.ascii_o); else pass_cnt++;
    total_cnt++; if (i0.digits_o !== 3'd2 || i0.overflow_o !== 1'b0) $display("FAIL basic_digits got %0d/%b want 2/0", i0.digits_o, i0.overflow_o); else pass_cnt++;
    total_cnt++; if (i1.ascii_o !== 40'h0000003533 || i1.len_bin_o !== 16'd35) $display("FAIL basic_overhead got %h/%0d want 3533/35", i1.ascii_o, i1.len_bin_o); else pass_cnt++;
    total_cnt++; if (i2.ascii_o !== 24'h003232 || i2.digits_o !== 2'd2 || !i2.valid_o) $display("FAIL basic_3dig got %h/%0d/%b want 3232/2/1", i2.ascii_o, i2.digits_o, i2.valid_o); else pass_cnt++;
    do_ack();
  endtask

  task automatic test_empty;
    start_msg();
    end_msg(k);
    total_cnt++; if (i0.ascii_o !== 40'h30 || i0.digits_o !== 3'd1 || i0.len_bin_o !== 16'd0) $display("FAIL empty_zero got %h/%0d/%0d want 30/1/0", i0.ascii_o, i0.digits_o, i0.len_bin_o); else pass_cnt++;
    total_cnt++; if (i1.ascii_o !== 40'h3331 || i1.digits_o !== 3'd2) $display("FAIL empty_overhead got %h/%0d want 3331/2", i1.ascii_o, i1.digits_o); else pass_cnt++;
    do_ack();
    start_msg();
    field(120);
    end_msg(k);
    total_cnt++; if (i1.ascii_o !== 40'h333331 || i1.digits_o !== 3'd3 || i1.len_bin_o !== 16'd133) $display("FAIL ovh_133 got %h/%0d/%0d want 333331/3/133", i1.ascii_o, i1.digits_o, i1.len_bin_o); else pass_cnt++;
    total_cnt++; if (i0.ascii_o !== 40'h303231 || i0.digits_o !== 3'd3) $display("FAIL plain_120 got %h/%0d want 303231/3", i0.ascii_o, i0.digits_o); else pass_cnt++;
    do_ack();
  endtask

  task automatic test_digit_overflow;
    start_msg();
    for (int i = 0; i < 4; i++) field(250);
    end_msg(k);
    total_cnt++; if (i2.overflow_o !== 1'b1 || i2.ascii_o !== 24'h393939 || i2.digits_o !== 2'd3) $display("FAIL dig_ovf got %b/%h/%0d want 1/393939/3", i2.overflow_o, i2.ascii_o, i2.digits_o); else pass_cnt++;
    total_cnt++; if (i2.len_bin_o !== 16'd1000) $display("FAIL dig_ovf_len got %0d want 1000", i2.len_bin_o); else pass_cnt++;
    total_cnt++; if (i0.ascii_o !== 40'h30303031 || i0.digits_o !== 3'd4 || i0.overflow_o !== 1'b0) $display("FAIL four_dig got %h/%0d/%b want 30303031/4/0", i0.ascii_o, i0.digits_o, i0.overflow_o); else pass_cnt++;
    total_cnt++; if (i1.ascii_o !== 40'h33313031) $display("FAIL four_dig_ovh got %h want 33313031", i1.ascii_o); else pass_cnt++;
    do_ack();
  endtask

  task automatic test_saturation;
    start_msg();
    for (int i = 0; i < 300; i++) field(255);
    end_msg(k);
    total_cnt++; if (i0.len_bin_o !== 16'hFFFF || i0.overflow_o !== 1'b1) $display("FAIL sat got %0d/%b want 65535/1", i0.len_bin_o, i0.overflow_o); else pass_cnt++;
    total_cnt++; if (i0.ascii_o !== 40'h3533353536 || i0.digits_o !== 3'd5) $display("FAIL sat_ascii got %h/%0d want 3533353536/5", i0.ascii_o, i0.digits_o); else pass_cnt++;
    total_cnt++; if (i1.len_bin_o !== 16'hFFFF || i1.overflow_o !== 1'b1) $display("FAIL sat_ovh got %0d/%b want 65535/1", i1.len_bin_o, i1.overflow_o); else pass_cnt++;
    total_cnt++; if (i2.ascii_o !== 24'h393939 || i2.overflow_o !== 1'b1) $display("FAIL sat_3dig got %h/%b want 393939/1", i2.ascii_o, i2.overflow_o); else pass_cnt++;
    do_ack();
  endtask

  task automatic test_handshake;
    int bad;
    start_msg();
    field(40);
    field(2);
    end_msg(k);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      tick();
      if (!i0.valid_o || i0.ascii_o !== 40'h3234 || i0.len_bin_o !== 16'd42 || i0.digits_o !== 3'd2) bad++;
    end
    start = 1'b0;
    total_cnt++; if (bad !== 0) $display("FAIL hold_stable got %0d unstable cycles want 0", bad); else pass_cnt++;
    do_ack();
    total_cnt++; if (i0.valid_o !== 1'b0 || i0.busy_o !== 1'b0) $display("FAIL ack_idle got %b/%b want 0/0", i0.valid_o, i0.busy_o); else pass_cnt++;
    start_msg();
    field(3);
    field(4);
    start = 1'b1;
    fv = 1'b1;
    fl = 8'd9;
    tick();
    start = 1'b0;
    fv = 1'b0;
    end_msg(k);
    total_cnt++; if (i0.len_bin_o !== 16'd9 || i0.ascii_o !== 40'h39 || i0.digits_o !== 3'd1) $display("FAIL restart got %0d/%h/%0d want 9/39/1", i0.len_bin_o, i0.ascii_o, i0.digits_o); else pass_cnt++;
    do_ack();
  endtask

  task automatic test_reset_conv;
    start_msg();
    field(100);
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++; if (i0.busy_o !== 1'b1 || i0.len_bin_o !== 16'd100) $display("FAIL conv_busy got %b/%0d want 1/100", i0.busy_o, i0.len_bin_o); else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total_cnt++; if ({i0.busy_o, i0.valid_o, i0.overflow_o} !== 3'b000 || i0.len_bin_o !== 16'd0 || i0.ascii_o !== 40'h0 || i0.digits_o !== 3'd0) $display("FAIL midconv_reset got %b%b%b/%0d/%h/%0d want 0", i0.busy_o, i0.valid_o, i0.overflow_o, i0.len_bin_o, i0.ascii_o, i0.digits_o); else pass_cnt++;
    start_msg();
    field(42);
    end_msg(k);
    total_cnt++; if (k !== 18 || i0.ascii_o !== 40'h3234 || i0.len_bin_o !== 16'd42 || i0.digits_o !== 3'd2) $display("FAIL post_reset got %0d/%h/%0d/%0d want 18/3234/42/2", k, i0.ascii_o, i0.len_bin_o, i0.digits_o); else pass_cnt++;
    do_ack();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_empty();
    test_digit_overflow();
    test_saturation();
    test_handshake();
    test_reset_conv();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout after %0d/%0d checks", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fix_bodylength_acc.md
Name: fix_bodylength_acc

Overview:
- Generalised FIX BodyLength(9) generator for the message builder.
- Accumulates per-field byte counts streamed by the field sequencer, adds a fixed overhead, and converts the total to left-justified ASCII decimal with a sequential shift-add-3 converter.
- Holds the result under a valid/ack handshake.
- Serves any message type, because the caller streams lengths instead of selecting a hard-coded sum.

Parameters:
- LEN_WIDTH, 16, width of the binary length accumulator.
- FIELD_LEN_WIDTH, 8, width of one field-length input.
- MAX_DIGITS, 5, maximum decimal digits produced; ascii_o is 8*MAX_DIGITS bits.
- FIXED_OVERHEAD, 0, constant byte count added once per message at end_i.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- start_i  in  1  begin a new message; clears the accumulator.
- field_valid_i  in  1  field_len_i is valid this cycle.
- field_len_i  in  FIELD_LEN_WIDTH  byte count of one tag=value<SOH> field.
- end_i  in  1  last field delivered; start conversion.
- ack_i  in  1  consumer has taken the result.
- busy_o  out  1  high whenever not IDLE.
- valid_o  out  1  result valid; held until ack_i.
- len_bin_o  out  LEN_WIDTH  binary total (saturated).
- ascii_o  out  8*MAX_DIGITS  digits; byte 0 (bits 7:0) is the most significant digit; unused high bytes are 0x00.
- digits_o  out  $clog2(MAX_DIGITS+1)  number of significant digits (at least 1).
- overflow_o  out  1  total saturated or did not fit in MAX_DIGITS.

Behaviour:
- Reset (rst==0 at a clock edge, any state, including mid-conversion):
  - State goes to IDLE.
  - All outputs go to 0.
  - The accumulator and converter registers are cleared.
- States:
  - IDLE: start_i -> ACCUM; accumulator is set to 0 and overflow is cleared.
  - ACCUM: each field_valid_i cycle adds field_len_i to the accumulator.
    - end_i -> CONV. The field on the same cycle as end_i is included, and FIXED_OVERHEAD is added in that same cycle.
    - start_i in ACCUM restarts the message. If start_i and field_valid_i arrive together, the field counts as the first field of the new message.
    - If start_i and end_i arrive together, start_i wins.
  - CONV: LEN_WIDTH cycles of double-dabble through the sub-module, then -> NORM. All inputs are ignored.
  - NORM: one cycle.
    - Counts leading-zero BCD digits and left-justifies the digits.
    - Adds 0x30 to each digit.
    - Sets digits_o.
    - Sets overflow_o if the value is >= 10^MAX_DIGITS; in that case ascii_o is all '9' (0x39) and digits_o = MAX_DIGITS.
    - -> HOLD.
  - HOLD: valid_o=1 and outputs are stable. ack_i -> IDLE, with valid_o low from the next cycle. start_i is ignored while busy_o=1.
- Arithmetic:
  - Unsigned saturating add at LEN_WIDTH.
  - On saturation the accumulator sticks at 2^LEN_WIDTH-1 and overflow is latched.
  - A total of 0 gives "0" (0x30) with digits_o=1.
- Latency: from end_i sampled at cycle t, valid_o rises at cycle t+LEN_WIDTH+2.
- len_bin_o is updated when entering CONV and is stable through HOLD.

Decomposition:
- Package fix_len_pkg:
  - state enum {IDLE, ACCUM, CONV, NORM, HOLD}
  - ASCII_ZERO = 8'h30, ASCII_NINE = 8'h39
  - a function giving the BCD width from MAX_DIGITS
- Sub-module bin2bcd_seq, parameterised on LEN_WIDTH and BCD digit count:
  - Inputs: start, binary value. Outputs: done pulse, BCD vector.
  - Synchronous active-low reset.
  - Internal BCD width is wide enough for the full LEN_WIDTH range (ceil(LEN_WIDTH*0.302)+1 digits), so overflow is detected in NORM.

Test Plan:
- Basic message:
  - Stimulus: start; fields 5, 7, 10 on consecutive cycles; end with no field.
  - Expected: valid_o exactly 18 cycles after end (LEN_WIDTH=16); len_bin_o=22; ascii_o byte0=0x32, byte1=0x32, bytes 2-4=0x00; digits_o=2; overflow_o=0.
- Empty message and overhead:
  - Stimulus: start, then end immediately with FIXED_OVERHEAD=0.
  - Expected: ascii_o byte0=0x30, digits_o=1.
  - Repeat with FIXED_OVERHEAD=13 and one field of 120: result "133" (0x31, 0x33, 0x33).
- Digit overflow (MAX_DIGITS=3):
  - Stimulus: fields totalling 1000.
  - Expected: overflow_o=1, ascii_o="999", digits_o=3, len_bin_o=1000.
- Saturation:
  - Stimulus: 300 fields of 255 (LEN_WIDTH=16).
  - Expected: len_bin_o=65535, overflow_o=1.
- Handshake and restart:
  - Hold ack_i low for 10 cycles: valid_o and data stay stable; start_i pulses during HOLD are ignored; ack -> IDLE next cycle.
  - start_i mid-ACCUM together with field 9, then end: total = 9.
- Reset mid-CONV:
  - Stimulus: drive rst=0 for one cycle during CONV.
  - Expected: next cycle all outputs 0, busy_o=0; a following message of 42 yields "42" correctly.
